// File: rtl/apb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// apb_cmd_sequencer
//
// Upstream stage of apb_topmodule. Host commands are buffered in a small
// FIFO and issued one at a time to the APB master's transfer interface.
// Each command produces exactly one single-cycle response: read data on
// normal completion, or an error flag when the master never signals pready
// within TIMEOUT wait cycles.
//
// Parameters
//   DEPTH    command FIFO entries (power of two, 2..16)
//   TIMEOUT  ACTIVE cycles without pready before the command is aborted
//
// Ports
//   pclk, preset            clock / asynchronous active-low reset
//   cmd_valid, cmd_ready    host command handshake
//   cmd_write, cmd_addr,
//   cmd_wdata               host command payload
//   transfer, read_write    request and direction to the APB master
//   apb_write_paddr,
//   apb_write_data,
//   apb_read_paddr          address/data to the APB master
//   pready, prdata          completion and read data from the master
//   rsp_valid, rsp_write,
//   rsp_rdata, rsp_err      one-cycle per-command response
//   fifo_count              occupied FIFO entries
// ---------------------------------------------------------------------------
module apb_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                     pclk,
   input  logic                     preset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [7:0]               cmd_addr,
   input  logic [7:0]               cmd_wdata,
   output logic                     transfer,
   output logic                     read_write,
   output logic [7:0]               apb_write_paddr,
   output logic [7:0]               apb_write_data,
   output logic [7:0]               apb_read_paddr,
   input  logic                     pready,
   input  logic [7:0]               prdata,
   output logic                     rsp_valid,
   output logic                     rsp_write,
   output logic [7:0]               rsp_rdata,
   output logic                     rsp_err,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      GAP
   } state_t;

   state_t          state;
   logic [16:0]     fifo_mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   wait_cnt;
   logic [16:0]     head;
   logic            head_write;
   logic [7:0]      head_addr;
   logic [7:0]      head_wdata;
   logic            push;
   logic            pop;
   logic            timed_out;

   // Ready comes straight from the registered count, so a pop in the same
   // cycle never lets a full FIFO accept a command.
   always_comb begin
      cmd_ready = (fifo_count < (PW + 1)'(DEPTH));
   end

   always_comb begin
      head       = fifo_mem[rd_ptr];
      head_write = head[16];
      head_addr  = head[15:8];
      head_wdata = head[7:0];
   end

   // The head is popped when the active command completes or times out;
   // pready takes priority over the timeout on the same cycle.
   always_comb begin
      timed_out = (wait_cnt == CW'(TIMEOUT));
      push      = cmd_valid && cmd_ready;
      pop       = (state == ACTIVE) && (pready || timed_out);
   end

   // -------------------------------------------------------------------
   // Command FIFO (pointers wrap naturally since DEPTH is a power of two)
   // -------------------------------------------------------------------
   always_ff @(posedge pclk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
      end
   end

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // -------------------------------------------------------------------
   // Issue FSM with registered outputs
   // -------------------------------------------------------------------
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         state           <= IDLE;
         wait_cnt        <= '0;
         transfer        <= 1'b0;
         read_write      <= 1'b0;
         apb_write_paddr <= '0;
         apb_write_data  <= '0;
         apb_read_paddr  <= '0;
         rsp_valid       <= 1'b0;
         rsp_write       <= 1'b0;
         rsp_rdata       <= '0;
         rsp_err         <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (fifo_count != '0) begin
                  state      <= ACTIVE;
                  transfer   <= 1'b1;
                  wait_cnt   <= '0;
                  read_write <= head_write;
                  if (head_write) begin
                     apb_write_paddr <= head_addr;
                     apb_write_data  <= head_wdata;
                     apb_read_paddr  <= '0;
                  end else begin
                     apb_write_paddr <= '0;
                     apb_write_data  <= '0;
                     apb_read_paddr  <= head_addr;
                  end
               end
            end
            ACTIVE: begin
               // read_write still holds the direction of the head entry,
               // so it doubles as the response type.
               if (pready) begin
                  state     <= GAP;
                  transfer  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_write <= read_write;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= read_write ? 8'h00 : prdata;
               end else if (timed_out) begin
                  state     <= GAP;
                  transfer  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_write <= read_write;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= 8'h00;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               transfer <= 1'b0;
            end
         endcase
      end
   end

endmodule
